// File: rtl/opa_fwd_stage.sv
// opa_fwd_stage
//   ALU operand-A select for the pipelined core. Picks operand A from rs1
//   (with EX/MEM forwarding), the PC, zero, or raw rs1, holds issue while a
//   load in EX still owes rs1, and registers the result into the ID/EX
//   boundary behind a valid/ready handshake.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   upstream (ID) handshake
//   a_sel               0 rs1 forwarded, 1 pc, 2 zero, 3 rs1 raw
//   rs1_addr, rs1_data  register index and regfile read data
//   pc                  PC of the instruction
//   ex_*                EX-stage write enable, rd, result, is-load flag
//   mem_*               MEM-stage write enable, rd, writeback data
//   flush               kill the held and the incoming operand
//   out_valid/out_ready downstream (EX) handshake
//   opa_out             registered operand A
//   fwd_src             0 regfile, 1 EX, 2 MEM, 3 non-rs1 source
//   stall_cnt           saturating count of load-use stall cycles

module opa_fwd_stage #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       a_sel,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  pc,
    input  logic             ex_wen,
    input  logic [AW-1:0]    ex_rd,
    input  logic [XLEN-1:0]  ex_data,
    input  logic             ex_is_load,
    input  logic             mem_wen,
    input  logic [AW-1:0]    mem_rd,
    input  logic [XLEN-1:0]  mem_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  opa_out,
    output logic [1:0]       fwd_src,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic            ex_hit;
    logic            mem_hit;
    logic            hazard;
    logic            capture;
    logic [XLEN-1:0] src_val;
    logic [1:0]      src_tag;

    // x0 never matches, so writes to x0 in later stages are never forwarded.
    assign ex_hit  = ex_wen  && (ex_rd  == rs1_addr) && (rs1_addr != '0);
    assign mem_hit = mem_wen && (mem_rd == rs1_addr) && (rs1_addr != '0);

    // Only the forwarded rs1 path cares about a load still in EX.
    assign hazard  = in_valid && (a_sel == 2'd0) && ex_hit && ex_is_load;

    // Flush is deliberately kept out of in_ready; it only blocks the capture.
    assign in_ready = !hazard && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        src_val = '0;
        src_tag = 2'd3;
        case (a_sel)
            2'd0: begin
                src_tag = 2'd0;
                if (rs1_addr == '0) begin
                    src_val = '0;
                end else if (ex_hit) begin
                    src_val = ex_data;
                    src_tag = 2'd1;
                end else if (mem_hit) begin
                    src_val = mem_data;
                    src_tag = 2'd2;
                end else begin
                    src_val = rs1_data;
                end
            end
            2'd1:    src_val = pc;
            2'd2:    src_val = '0;
            default: src_val = rs1_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            opa_out   <= '0;
            fwd_src   <= 2'd0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (capture) begin
                out_valid <= 1'b1;
                opa_out   <= src_val;
                fwd_src   <= src_tag;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (hazard && !flush && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

endmodule
